opb_master_single: RTL and testbench
====================================

Name: opb_master_single

Overview:
- Single-beat OPB bus master: issues one read or write per user command and returns one response.
- Used by fabric logic (e.g. a link-status poller) to reach the OPB slave registers that the PPC normally reads.
- Sits beside the PPC as a second master on the same OPB arbiter.
- Bus outputs are zero whenever the master is not selected, so they can be OR-ed onto the OPB.

Parameters:
- TOUT_CYCLES, 16: cycles with M_select high and no ack/errAck/retry before the master aborts with TIMEOUT; must be ≥2.
- MAX_RETRY, 3: re-issues allowed after OPB_retry. Used only with OPB_MASTER_RETRY_EN.
- C_OPB_AWIDTH, 32: address width; fixed at 32.
- C_OPB_DWIDTH, 32: data width; fixed at 32.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  32  byte address [31:0].
- cmd_data  in  32  write data [31:0].
- cmd_be  in  4  byte enables [3:0].
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  32  read data; 0 for writes and for failed transfers.
- rsp_status  out  2  0 OK, 1 ERR, 2 TIMEOUT, 3 RETRY_EXHAUSTED.
- M_request  out  1  bus request to arbiter.
- M_select  out  1  master drives bus.
- M_RNW  out  1  read/not-write.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- M_seqAddr  out  1  tied 0.
- M_busLock  out  1  tied 0.
- OPB_MGrant  in  1  grant.
- OPB_xferAck  in  1  transfer acknowledge.
- OPB_errAck  in  1  error acknowledge.
- OPB_retry  in  1  slave retry.
- OPB_toutSup  in  1  timeout suppress.
- OPB_DBus  in  [0:31]  read data.

Behaviour:
- Reset (OPB_Rst low, asynchronous):
  - State = IDLE.
  - cmd_ready=1; every other output 0, including rsp_*.
  - Command latch, timeout counter and retry counter cleared.
  - Reset mid-transfer drops M_select/M_request immediately; no response is emitted.
- Bit mapping: MSB to MSB. cmd_addr[31] → M_ABus[0]; OPB_DBus[0] → rsp_data[31]; cmd_be[3] → M_BE[0].
- FSM states:
  - IDLE:
    - cmd_ready=1.
    - On a handshake, latch rnw/addr/data/be, clear the retry count, go to REQ.
  - REQ:
    - M_request=1.
    - OPB_MGrant sampled high → next cycle SEL.
  - SEL:
    - M_select=1; M_RNW, M_ABus, M_BE driven; M_DBus driven only for writes (else 0); M_request=0.
    - Timeout counter increments each cycle while OPB_toutSup=0. It holds while OPB_toutSup=1.
    - Exits, by priority when sampled together:
      - OPB_errAck → RESP, status ERR.
      - OPB_xferAck → RESP, status OK; read data captured from OPB_DBus that cycle.
      - OPB_retry → RETRY handling.
      - Counter reaches TOUT_CYCLES → RESP, status TIMEOUT.
    - M_select and all bus outputs drop to 0 the cycle after exit.
  - RESP:
    - rsp_valid=1 for exactly one cycle with rsp_data/rsp_status, then IDLE.
    - cmd_ready=0 in RESP.
    - Earliest new command acceptance is the cycle after rsp_valid.
- cmd_ready is 0 in every state except IDLE.
- Latency, zero-wait grant and ack: accept (c0), M_request (c1), MGrant (c1), M_select (c2), xferAck (c2), rsp_valid (c3).
- Timeout counter clears on entry to SEL.
- cmd_* changes while busy have no effect on the transfer.

Optional Feature:
- Macro: OPB_MASTER_RETRY_EN.
- Defined:
  - OPB_retry in SEL → drop select, idle one cycle, return to REQ.
  - The retry count increments on each retry.
  - A retry when count == MAX_RETRY → RESP with RETRY_EXHAUSTED.
- Undefined:
  - OPB_retry → RESP with status ERR; no retry counter is synthesised.

Decomposition:
- Package opb_master_pkg:
  - state enum (IDLE, REQ, SEL, RETRY_GAP, RESP);
  - rsp_status encodings RSP_OK/RSP_ERR/RSP_TOUT/RSP_RETRY_EXH;
  - OPB width constants.
- Sub-module opb_master_tout_cnt: counter with clear, enable (~OPB_toutSup) and terminal flag at TOUT_CYCLES.

Test Plan:
- Write 0xDEADBEEF to 0x01100300, BE=0xF, grant and ack immediate → M_ABus=0x01100300, M_DBus=0xDEADBEEF for exactly one select cycle; rsp_valid at c3, status OK, rsp_data 0.
- Read 0x01100300; slave acks on the 3rd select cycle with OPB_DBus=0x00000001 → rsp_data=0x00000001, OK; bus outputs 0 afterwards.
- No ack, toutSup=0 → rsp_status TIMEOUT exactly TOUT_CYCLES=16 select cycles after select; toutSup held high 40 cycles then ack → OK, no timeout.
- errAck and xferAck in the same cycle → ERR; grant delayed 5 cycles → M_select never before the cycle after grant.
- With OPB_MASTER_RETRY_EN, retry on 4 consecutive attempts → 4 select phases, then RETRY_EXHAUSTED; without the macro, the first retry gives ERR.
- Assert reset during SEL → all outputs 0 asynchronously, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/opb_master_pkg.sv
// Shared state encoding, response codes and bus widths for the single-beat OPB master.
package opb_master_pkg;

  localparam int unsigned OPB_AWIDTH  = 32;
  localparam int unsigned OPB_DWIDTH  = 32;
  localparam int unsigned OPB_BEWIDTH = OPB_DWIDTH / 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    SEL       = 3'd2,
    RETRY_GAP = 3'd3,
    RESP      = 3'd4
  } state_e;

  typedef logic [1:0] rsp_status_t;

  localparam rsp_status_t RSP_OK        = 2'd0;
  localparam rsp_status_t RSP_ERR       = 2'd1;
  localparam rsp_status_t RSP_TOUT      = 2'd2;
  localparam rsp_status_t RSP_RETRY_EXH = 2'd3;

endpackage

// File: rtl/opb_master_tout_cnt.sv
// Select-phase timeout counter: held at zero by clr, advances while en, and
// flags the cycle in which the count reaches TOUT_CYCLES.
module opb_master_tout_cnt #(
  parameter int unsigned TOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int unsigned   CW   = $clog2(TOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal in the cycle whose increment would make the count TOUT_CYCLES.
  assign term = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/opb_master_single.sv
// Single-beat OPB master: one read or write per command, one response strobe.
// Optional retry re-issue is enabled by defining OPB_MASTER_RETRY_EN.
module opb_master_single #(
  parameter int unsigned TOUT_CYCLES = 16
`ifdef OPB_MASTER_RETRY_EN
  ,
  parameter int unsigned MAX_RETRY   = 3
`endif
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rnw,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        M_request,
  output logic        M_select,
  output logic        M_RNW,
  output logic [0:31] M_ABus,
  output logic [0:3]  M_BE,
  output logic [0:31] M_DBus,
  output logic        M_seqAddr,
  output logic        M_busLock,
  input  logic        OPB_MGrant,
  input  logic        OPB_xferAck,
  input  logic        OPB_errAck,
  input  logic        OPB_retry,
  input  logic        OPB_toutSup,
  input  logic [0:31] OPB_DBus
);

  import opb_master_pkg::*;

  state_e                 state_q, state_d;
  logic                   rnw_q, rnw_d;
  logic [OPB_AWIDTH-1:0]  addr_q, addr_d;
  logic [OPB_DWIDTH-1:0]  wdata_q, wdata_d;
  logic [OPB_BEWIDTH-1:0] be_q, be_d;
  logic [OPB_DWIDTH-1:0]  rdata_q, rdata_d;
  rsp_status_t            status_q, status_d;
  logic                   tout_term;

`ifdef OPB_MASTER_RETRY_EN
  localparam int unsigned   RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
`endif

  opb_master_tout_cnt #(
    .TOUT_CYCLES (TOUT_CYCLES)
  ) u_tout_cnt (
    .clk   (OPB_Clk),
    .rst_n (OPB_Rst),
    .clr   (state_q != SEL),
    .en    ((state_q == SEL) && !OPB_toutSup),
    .term  (tout_term)
  );

  // Next-state, command latch and response capture.
  always_comb begin
    state_d  = state_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    status_d = status_q;
`ifdef OPB_MASTER_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rnw_d    = cmd_rnw;
          addr_d   = cmd_addr;
          wdata_d  = cmd_data;
          be_d     = cmd_be;
          rdata_d  = '0;
          status_d = RSP_OK;
`ifdef OPB_MASTER_RETRY_EN
          retry_cnt_d = '0;
`endif
          state_d  = REQ;
        end else begin
          state_d  = IDLE;
        end
      end
      REQ: begin
        if (OPB_MGrant) begin
          state_d = SEL;
        end else begin
          state_d = REQ;
        end
      end
      SEL: begin
        if (OPB_errAck) begin
          status_d = RSP_ERR;
          state_d  = RESP;
        end else if (OPB_xferAck) begin
          status_d = RSP_OK;
          if (rnw_q) begin
            rdata_d = OPB_DBus;
          end else begin
            rdata_d = '0;
          end
          state_d  = RESP;
        end else if (OPB_retry) begin
`ifdef OPB_MASTER_RETRY_EN
          if (retry_cnt_q == RETRY_LIMIT) begin
            status_d = RSP_RETRY_EXH;
            state_d  = RESP;
          end else begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            state_d     = RETRY_GAP;
          end
`else
          status_d = RSP_ERR;
          state_d  = RESP;
`endif
        end else if (tout_term) begin
          status_d = RSP_TOUT;
          state_d  = RESP;
        end else begin
          state_d  = SEL;
        end
      end
      RETRY_GAP: state_d = REQ;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode; everything not owned by the current state stays zero so the
  // bus side can be OR-ed with other masters.
  always_comb begin
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_status = RSP_OK;
    M_request  = 1'b0;
    M_select   = 1'b0;
    M_RNW      = 1'b0;
    M_ABus     = '0;
    M_BE       = '0;
    M_DBus     = '0;
    case (state_q)
      IDLE: cmd_ready = 1'b1;
      REQ:  M_request = 1'b1;
      SEL: begin
        M_select = 1'b1;
        M_RNW    = rnw_q;
        M_ABus   = addr_q;
        M_BE     = be_q;
        if (rnw_q) begin
          M_DBus = '0;
        end else begin
          M_DBus = wdata_q;
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_data   = rdata_q;
        rsp_status = status_q;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign M_seqAddr = 1'b0;
  assign M_busLock = 1'b0;

  // State and command/response registers.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state_q  <= IDLE;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      status_q <= RSP_OK;
    end else begin
      state_q  <= state_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

`ifdef OPB_MASTER_RETRY_EN
  // Retry attempt counter.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      retry_cnt_q <= '0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_opb_master_single.sv
// Directed self-checking bench for opb_master_single (follows OPB_MASTER_RETRY_EN if defined).
module tb_opb_master_single;

  import opb_master_pkg::*;

  logic        OPB_Clk;
  logic        OPB_Rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rnw;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        M_request;
  logic        M_select;
  logic        M_RNW;
  logic [0:31] M_ABus;
  logic [0:3]  M_BE;
  logic [0:31] M_DBus;
  logic        M_seqAddr;
  logic        M_busLock;
  logic        OPB_MGrant;
  logic        OPB_xferAck;
  logic        OPB_errAck;
  logic        OPB_retry;
  logic        OPB_toutSup;
  logic [0:31] OPB_DBus;

  int n_checks = 0;
  int n_fail   = 0;

  opb_master_single #(.TOUT_CYCLES(16)) dut (
    .OPB_Clk     (OPB_Clk),
    .OPB_Rst     (OPB_Rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rnw     (cmd_rnw),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_be      (cmd_be),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_status  (rsp_status),
    .M_request   (M_request),
    .M_select    (M_select),
    .M_RNW       (M_RNW),
    .M_ABus      (M_ABus),
    .M_BE        (M_BE),
    .M_DBus      (M_DBus),
    .M_seqAddr   (M_seqAddr),
    .M_busLock   (M_busLock),
    .OPB_MGrant  (OPB_MGrant),
    .OPB_xferAck (OPB_xferAck),
    .OPB_errAck  (OPB_errAck),
    .OPB_retry   (OPB_retry),
    .OPB_toutSup (OPB_toutSup),
    .OPB_DBus    (OPB_DBus)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge OPB_Clk);
    #1;
  endtask

  task automatic check_bus_idle(input string tag);
    check_eq({tag, "_ctl"}, {27'd0, M_select, M_request, M_RNW, M_seqAddr, M_busLock}, 32'd0);
    check_eq({tag, "_abus"}, M_ABus, 32'd0);
    check_eq({tag, "_dbus"}, M_DBus, 32'd0);
    check_eq({tag, "_be"}, {28'd0, M_BE}, 32'd0);
  endtask

  // Offer a command in IDLE; returns one cycle later in REQ with cmd_* scrambled.
  task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
    cmd_rnw   = rnw;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_be    = be;
    cmd_valid = 1'b1;
    check_eq("issue_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_rnw   = ~rnw;
    cmd_addr  = ~addr;
    cmd_data  = ~data;
    cmd_be    = ~be;
    check_eq("req_request", {31'd0, M_request}, 32'd1);
    check_eq("req_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("req_select", {31'd0, M_select}, 32'd0);
  endtask

  // Hold grant low for n cycles, then grant; returns in the first select cycle.
  task automatic grant(input int n);
    for (int i = 0; i < n; i++) begin
      check_eq("wait_request", {31'd0, M_request}, 32'd1);
      check_eq("wait_select", {31'd0, M_select}, 32'd0);
      tick();
    end
    OPB_MGrant = 1'b1;
    check_eq("grant_select", {31'd0, M_select}, 32'd0);
    tick();
    OPB_MGrant = 1'b0;
    check_eq("sel_select", {31'd0, M_select}, 32'd1);
    check_eq("sel_request", {31'd0, M_request}, 32'd0);
  endtask

  task automatic expect_sel(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
    check_eq("sel_rnw", {31'd0, M_RNW}, {31'd0, rnw});
    check_eq("sel_abus", M_ABus, addr);
    check_eq("sel_dbus", M_DBus, rnw ? 32'd0 : data);
    check_eq("sel_be", {28'd0, M_BE}, {28'd0, be});
  endtask

  task automatic expect_rsp(input logic [1:0] status, input logic [31:0] data);
    check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rsp_status", {30'd0, rsp_status}, {30'd0, status});
    check_eq("rsp_data", rsp_data, data);
    check_eq("rsp_ready", {31'd0, cmd_ready}, 32'd0);
    check_bus_idle("rsp_bus");
    tick();
    check_eq("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("post_rsp_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    OPB_Rst     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_rnw     = 1'b0;
    cmd_addr    = 32'd0;
    cmd_data    = 32'd0;
    cmd_be      = 4'd0;
    OPB_MGrant  = 1'b0;
    OPB_xferAck = 1'b0;
    OPB_errAck  = 1'b0;
    OPB_retry   = 1'b0;
    OPB_toutSup = 1'b0;
    OPB_DBus    = 32'd0;
    repeat (3) tick();
    check_eq("reset_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("reset_rsp", {rsp_data[29:0], rsp_status[0], rsp_valid}, 32'd0);
    check_bus_idle("reset_bus");
    OPB_Rst = 1'b1;
    tick();

    // Write, zero-wait grant and ack: select for exactly one cycle.
    issue(1'b0, 32'h0110_0300, 32'hDEAD_BEEF, 4'hF);
    grant(0);
    expect_sel(1'b0, 32'h0110_0300, 32'hDEAD_BEEF, 4'hF);
    OPB_xferAck = 1'b1;
    tick();
    OPB_xferAck = 1'b0;
    expect_rsp(RSP_OK, 32'd0);

    // Read acked on the third select cycle.
    issue(1'b1, 32'h0110_0300, 32'h5555_AAAA, 4'hF);
    grant(0);
    expect_sel(1'b1, 32'h0110_0300, 32'd0, 4'hF);
    tick();
    check_eq("read_sel2", {31'd0, M_select}, 32'd1);
    tick();
    check_eq("read_sel3", {31'd0, M_select}, 32'd1);
    OPB_DBus    = 32'h0000_0001;
    OPB_xferAck = 1'b1;
    tick();
    OPB_xferAck = 1'b0;
    OPB_DBus    = 32'd0;
    expect_rsp(RSP_OK, 32'h0000_0001);

    // No ack: abort after 16 select cycles.
    issue(1'b0, 32'h0000_0040, 32'h0000_1234, 4'h3);
    grant(0);
    expect_sel(1'b0, 32'h0000_0040, 32'h0000_1234, 4'h3);
    for (int i = 1; i <= 16; i++) begin
      check_eq($sformatf("tout_sel_%0d", i), {31'd0, M_select}, 32'd1);
      tick();
    end
    expect_rsp(RSP_TOUT, 32'd0);

    // Suppression pauses the count: 5 + 11 counted cycles around a 10-cycle hold.
    issue(1'b1, 32'h0000_0080, 32'd0, 4'hF);
    grant(0);
    for (int i = 1; i <= 26; i++) begin
      OPB_toutSup = (i >= 6 && i <= 15);
      check_eq($sformatf("hold_sel_%0d", i), {31'd0, M_select}, 32'd1);
      tick();
    end
    OPB_toutSup = 1'b0;
    expect_rsp(RSP_TOUT, 32'd0);

    // Suppressed for 40 cycles, then acked with read data.
    OPB_toutSup = 1'b1;
    issue(1'b1, 32'h8000_0004, 32'd0, 4'h8);
    grant(0);
    expect_sel(1'b1, 32'h8000_0004, 32'd0, 4'h8);
    for (int i = 1; i <= 40; i++) begin
      check_eq($sformatf("sup_sel_%0d", i), {31'd0, M_select}, 32'd1);
      tick();
    end
    OPB_DBus    = 32'h1234_5678;
    OPB_xferAck = 1'b1;
    tick();
    OPB_xferAck = 1'b0;
    OPB_toutSup = 1'b0;
    OPB_DBus    = 32'd0;
    expect_rsp(RSP_OK, 32'h1234_5678);

    // Grant delayed 5 cycles; errAck beats xferAck and read data is dropped.
    issue(1'b1, 32'h0110_0304, 32'd0, 4'hF);
    grant(5);
    OPB_DBus    = 32'hFFFF_FFFF;
    OPB_errAck  = 1'b1;
    OPB_xferAck = 1'b1;
    tick();
    OPB_errAck  = 1'b0;
    OPB_xferAck = 1'b0;
    OPB_DBus    = 32'd0;
    expect_rsp(RSP_ERR, 32'd0);

`ifdef OPB_MASTER_RETRY_EN
    // Four retried select phases, the last one exhausts the budget.
    issue(1'b0, 32'h0000_0100, 32'hCAFE_0001, 4'hF);
    for (int a = 1; a <= 4; a++) begin
      grant(0);
      OPB_retry = 1'b1;
      tick();
      OPB_retry = 1'b0;
      if (a < 4) begin
        check_eq($sformatf("gap_%0d", a), {30'd0, M_select, M_request}, 32'd0);
        check_eq($sformatf("gap_rsp_%0d", a), {31'd0, rsp_valid}, 32'd0);
        tick();
        check_eq($sformatf("rereq_%0d", a), {31'd0, M_request}, 32'd1);
      end
    end
    expect_rsp(RSP_RETRY_EXH, 32'd0);
`else
    // Without retry support the first retry is an error.
    issue(1'b0, 32'h0000_0100, 32'hCAFE_0001, 4'hF);
    grant(0);
    OPB_retry = 1'b1;
    tick();
    OPB_retry = 1'b0;
    expect_rsp(RSP_ERR, 32'd0);
`endif

    // Reset mid-select clears outputs at once and emits no response.
    issue(1'b0, 32'h0000_0200, 32'h0BAD_F00D, 4'hF);
    grant(0);
    #2;
    OPB_Rst = 1'b0;
    #1;
    check_bus_idle("rst_bus");
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("rst_rsp2", {31'd0, rsp_valid}, 32'd0);
    OPB_Rst = 1'b1;
    tick();
    check_eq("rst_rsp3", {31'd0, rsp_valid}, 32'd0);
    issue(1'b0, 32'h0000_0010, 32'h0F0F_1234, 4'h3);
    grant(0);
    expect_sel(1'b0, 32'h0000_0010, 32'h0F0F_1234, 4'h3);
    OPB_xferAck = 1'b1;
    tick();
    OPB_xferAck = 1'b0;
    expect_rsp(RSP_OK, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
